// File: rtl/vxe_vpu_gen_ecu.sv
// ---------------------------------------------------------------------------
// vxe_vpu_gen_ecu
// Generalised VPU execution control unit. It takes one dispatched command at a
// time, checks the opcode, pulses start to a masked subset of execution units,
// and reports done once every started unit has gone idle. A one-entry pending
// buffer lets the dispatcher queue a command while another one is running.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_disp / o_rdy      dispatch strobe; accepted when i_disp && o_rdy
//   i_cmd_op/th/pl      command opcode, thread id, payload
//   i_eu_en             unit enable mask, captured with the command
//   i_to_limit          watchdog limit in WAIT cycles (0 disables it)
//   o_done / o_err      one-cycle completion pulse, error flag on the same cycle
//   o_err_code          01 bad opcode, 10 timeout, 00 ok; held until next done
//   o_eu_start          one-cycle start pulse per enabled unit
//   o_eu_th / o_eu_pl   thread and payload of the running command
//   i_eu_busy           per-unit busy flags
// ---------------------------------------------------------------------------
module vxe_vpu_gen_ecu #(
    parameter int         N_EU     = 8,
    parameter int         BUSY_DLY = 1,
    parameter int         TO_W     = 16,
    parameter logic [4:0] EXP_OP   = 5'h04   // CU_CMD_STORE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_disp,
    output logic            o_rdy,
    input  logic [4:0]      i_cmd_op,
    input  logic [2:0]      i_cmd_th,
    input  logic [47:0]     i_cmd_pl,
    input  logic [N_EU-1:0] i_eu_en,
    input  logic [TO_W-1:0] i_to_limit,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_err_code,
    output logic [N_EU-1:0] o_eu_start,
    output logic [2:0]      o_eu_th,
    output logic [47:0]     o_eu_pl,
    input  logic [N_EU-1:0] i_eu_busy
);

    // HOLD counts 0 .. BUSY_DLY-2; it is never entered when BUSY_DLY == 1.
    localparam int              HW        = (BUSY_DLY > 1) ? $clog2(BUSY_DLY) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'((BUSY_DLY > 1) ? (BUSY_DLY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [HW-1:0]   hold_r, hold_s;
    logic [TO_W-1:0] wd_r, wd_s, wd_inc_s;
    logic [N_EU-1:0] en_r, en_s;
    logic            done_r, done_s;
    logic            err_r, err_s;
    logic [1:0]      code_r, code_s;
    logic [N_EU-1:0] start_r, start_s;
    logic [2:0]      th_r, th_s;
    logic [47:0]     pl_r, pl_s;

    logic            pend_vld_r, pend_vld_s;
    logic [4:0]      pend_op_r, pend_op_s;
    logic [2:0]      pend_th_r, pend_th_s;
    logic [47:0]     pend_pl_r, pend_pl_s;
    logic [N_EU-1:0] pend_en_r, pend_en_s;

    logic            accept_s, launch_ok_s, launch_s, bypass_s, busy_any_s;
    logic [4:0]      l_op_s;
    logic [2:0]      l_th_s;
    logic [47:0]     l_pl_s;
    logic [N_EU-1:0] l_en_s;

    // Next-state, pending-entry and output computation.
    always_comb begin
        state_s    = state_r;
        hold_s     = hold_r;
        wd_s       = wd_r;
        en_s       = en_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        code_s     = code_r;
        start_s    = '0;
        th_s       = th_r;
        pl_s       = pl_r;
        pend_vld_s = pend_vld_r;
        pend_op_s  = pend_op_r;
        pend_th_s  = pend_th_r;
        pend_pl_s  = pend_pl_r;
        pend_en_s  = pend_en_r;

        accept_s    = i_disp && !pend_vld_r;
        // The done cycle itself never launches, guaranteeing one idle cycle
        // between o_done and the next start pulse.
        launch_ok_s = (state_r == ST_IDLE) && !done_r;
        bypass_s    = launch_ok_s && !pend_vld_r && accept_s;
        launch_s    = launch_ok_s && (pend_vld_r || accept_s);
        busy_any_s  = |(i_eu_busy & en_r);
        wd_inc_s    = (wd_r == {TO_W{1'b1}}) ? wd_r : (wd_r + {{(TO_W-1){1'b0}}, 1'b1});

        if (pend_vld_r) begin
            l_op_s = pend_op_r;
            l_th_s = pend_th_r;
            l_pl_s = pend_pl_r;
            l_en_s = pend_en_r;
        end else begin
            l_op_s = i_cmd_op;
            l_th_s = i_cmd_th;
            l_pl_s = i_cmd_pl;
            l_en_s = i_eu_en;
        end

        // Pending entry: freed by a launch, filled by any accept that is not bypassed.
        if (launch_ok_s && pend_vld_r) begin
            pend_vld_s = 1'b0;
        end else begin
            pend_vld_s = pend_vld_r;
        end
        if (accept_s && !bypass_s) begin
            pend_vld_s = 1'b1;
            pend_op_s  = i_cmd_op;
            pend_th_s  = i_cmd_th;
            pend_pl_s  = i_cmd_pl;
            pend_en_s  = i_eu_en;
        end else begin
            pend_vld_s = pend_vld_s;
        end

        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    if (l_op_s != EXP_OP) begin
                        done_s = 1'b1;
                        err_s  = 1'b1;
                        code_s = 2'b01;
                    end else begin
                        start_s = l_en_s;
                        en_s    = l_en_s;
                        th_s    = l_th_s;
                        pl_s    = l_pl_s;
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (BUSY_DLY > 1) begin
                    hold_s  = '0;
                    state_s = ST_HOLD;
                end else begin
                    wd_s    = '0;
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (hold_r == HOLD_LAST) begin
                    wd_s    = '0;
                    state_s = ST_WAIT;
                end else begin
                    hold_s  = hold_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT: begin
                if (!busy_any_s) begin
                    done_s  = 1'b1;
                    code_s  = 2'b00;
                    state_s = ST_IDLE;
                end else if ((i_to_limit != {TO_W{1'b0}}) && (wd_inc_s >= i_to_limit)) begin
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    code_s  = 2'b10;
                    state_s = ST_IDLE;
                end else begin
                    wd_s    = wd_inc_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pending entry and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_r     <= '0;
            wd_r       <= '0;
            en_r       <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            code_r     <= 2'b00;
            start_r    <= '0;
            th_r       <= 3'd0;
            pl_r       <= 48'd0;
            pend_vld_r <= 1'b0;
            pend_op_r  <= 5'd0;
            pend_th_r  <= 3'd0;
            pend_pl_r  <= 48'd0;
            pend_en_r  <= '0;
        end else begin
            state_r    <= state_s;
            hold_r     <= hold_s;
            wd_r       <= wd_s;
            en_r       <= en_s;
            done_r     <= done_s;
            err_r      <= err_s;
            code_r     <= code_s;
            start_r    <= start_s;
            th_r       <= th_s;
            pl_r       <= pl_s;
            pend_vld_r <= pend_vld_s;
            pend_op_r  <= pend_op_s;
            pend_th_r  <= pend_th_s;
            pend_pl_r  <= pend_pl_s;
            pend_en_r  <= pend_en_s;
        end
    end

    assign o_rdy      = !pend_vld_r;
    assign o_done     = done_r;
    assign o_err      = err_r;
    assign o_err_code = code_r;
    assign o_eu_start = start_r;
    assign o_eu_th    = th_r;
    assign o_eu_pl    = pl_r;

endmodule
